// File: rtl/ram_fake_pkg.sv
// Shared constants and helpers for the stand-in multi-port memory:
// scrambler step, write-strobe population count and saturating counter increment.
package ram_fake_pkg;

  localparam int CMaxDataLen = 1024;
  localparam logic [31:0] CSeedDflt = 32'h1;

  typedef logic [CMaxDataLen-1:0] scr_vec_t;

  // Callers zero-extend their state and truncate the result back to their
  // own width; the bit shifted past the top of the narrow state is discarded.
  function automatic scr_vec_t ScrStep(input scr_vec_t state, input logic fb);
    return state ^ {state[CMaxDataLen-2:0], fb};
  endfunction

  function automatic logic [2:0] PopCnt(input logic [3:0] vec);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < 4; i++) cnt = cnt + 3'(vec[i]);
    return cnt;
  endfunction

  function automatic logic [31:0] SatInc(input logic [31:0] cnt, input logic [2:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + 33'(inc);
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/ram_fake_lane.sv
// One port of the fake memory: traffic-driven scrambler plus the read pipeline
// that returns scrambler snapshots after a fixed number of enabled cycles.
module ram_fake_lane
  import ram_fake_pkg::*;
#(
  parameter int CAddrLen = 13,
  parameter int CDataLen = 128,
  parameter int CRdLat = 1,
  parameter logic [CDataLen-1:0] CSeedLane = 1
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                en,
  input  logic [CAddrLen-1:0] addr,
  input  logic [CDataLen-1:0] mosi,
  input  logic                wr_en,
  input  logic                rd_en,
  output logic [CDataLen-1:0] miso,
  output logic                rd_vld
);

  logic [CDataLen-1:0] scr_reg;
  logic [CDataLen-1:0] scr_next;
  logic                fb;
  logic [CDataLen-1:0] pipe_data_reg [CRdLat];
  logic                pipe_vld_reg  [CRdLat];

  assign fb       = ^{addr, mosi, wr_en, rd_en};
  assign scr_next = CDataLen'(ScrStep(scr_vec_t'(scr_reg), fb));

  // Stage data is cleared on empty slots so the last stage can drive miso directly.
  always_ff @(posedge clk) begin
    if (srst) begin
      scr_reg <= CSeedLane;
      for (int i = 0; i < CRdLat; i++) begin
        pipe_data_reg[i] <= '0;
        pipe_vld_reg[i]  <= 1'b0;
      end
    end else if (en) begin
      scr_reg          <= scr_next;
      pipe_vld_reg[0]  <= rd_en;
      pipe_data_reg[0] <= rd_en ? scr_reg : '0;
      for (int i = 1; i < CRdLat; i++) begin
        pipe_vld_reg[i]  <= pipe_vld_reg[i-1];
        pipe_data_reg[i] <= pipe_data_reg[i-1];
      end
    end
  end

  assign miso   = pipe_data_reg[CRdLat-1];
  assign rd_vld = pipe_vld_reg[CRdLat-1];

endmodule

// File: rtl/ram_fake_mx.sv
// Multi-port stand-in memory: independent scrambler lanes for read data,
// plus a saturating write counter and a write-data signature.
module ram_fake_mx
  import ram_fake_pkg::*;
#(
  parameter int CAddrLen = 13,
  parameter int CDataLen = 128,
  parameter int CPortCnt = 2,
  parameter int CRdLat = 1,
  parameter logic [CDataLen-1:0] CSeed = CDataLen'(CSeedDflt)
) (
  input  logic                         AClkH,
  input  logic                         AResetH,
  input  logic                         AClkHEn,
  input  logic [CPortCnt*CAddrLen-1:0] AAddr,
  input  logic [CPortCnt*CDataLen-1:0] AMosi,
  input  logic [CPortCnt-1:0]          AWrEn,
  input  logic [CPortCnt-1:0]          ARdEn,
  output logic [CPortCnt*CDataLen-1:0] AMiso,
  output logic [CPortCnt-1:0]          ARdVld,
  output logic [31:0]                  AWrCnt,
  output logic [CDataLen-1:0]          ASig
);

  logic [31:0]         wr_cnt_reg;
  logic [CDataLen-1:0] sig_reg;
  logic [CDataLen-1:0] sig_mix;

  for (genvar gi = 0; gi < CPortCnt; gi++) begin : g_lane
    ram_fake_lane #(
      .CAddrLen (CAddrLen),
      .CDataLen (CDataLen),
      .CRdLat   (CRdLat),
      .CSeedLane(CSeed ^ CDataLen'(gi))
    ) u_lane (
      .clk   (AClkH),
      .srst  (AResetH),
      .en    (AClkHEn),
      .addr  (AAddr[gi*CAddrLen +: CAddrLen]),
      .mosi  (AMosi[gi*CDataLen +: CDataLen]),
      .wr_en (AWrEn[gi]),
      .rd_en (ARdEn[gi]),
      .miso  (AMiso[gi*CDataLen +: CDataLen]),
      .rd_vld(ARdVld[gi])
    );
  end

  always_comb begin
    sig_mix = '0;
    for (int p = 0; p < CPortCnt; p++)
      if (AWrEn[p]) sig_mix = sig_mix ^ AMosi[p*CDataLen +: CDataLen];
  end

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      wr_cnt_reg <= '0;
      sig_reg    <= '0;
    end else if (AClkHEn) begin
      wr_cnt_reg <= SatInc(wr_cnt_reg, PopCnt(4'(AWrEn)));
      if (|AWrEn) sig_reg <= {sig_reg[CDataLen-2:0], sig_reg[CDataLen-1]} ^ sig_mix;
    end
  end

  assign AWrCnt = wr_cnt_reg;
  assign ASig   = sig_reg;

endmodule

// File: tb/tb_ram_fake_mx.sv
// Scoreboard bench: three instances (read latency 1, 3, 2) share a clock but
// get separate directed stimulus; a monitor matches every valid against a queue.
module tb_ram_fake_mx;

  localparam int W = 8;
  localparam int A = 13;
  localparam int P = 2;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst  [N];
  logic           en   [N];
  logic [P*A-1:0] addr [N];
  logic [P*W-1:0] mosi [N];
  logic [P-1:0]   wr   [N];
  logic [P-1:0]   rd   [N];
  logic [P*W-1:0] miso [N];
  logic [P-1:0]   vld  [N];
  logic [31:0]    cnt  [N];
  logic [W-1:0]   sig  [N];

  ram_fake_mx #(.CAddrLen(A), .CDataLen(W), .CPortCnt(P), .CRdLat(1), .CSeed(8'h01)) u_mx0 (
    .AClkH(clk), .AResetH(rst[0]), .AClkHEn(en[0]), .AAddr(addr[0]), .AMosi(mosi[0]),
    .AWrEn(wr[0]), .ARdEn(rd[0]), .AMiso(miso[0]), .ARdVld(vld[0]), .AWrCnt(cnt[0]), .ASig(sig[0]));
  ram_fake_mx #(.CAddrLen(A), .CDataLen(W), .CPortCnt(P), .CRdLat(3), .CSeed(8'h01)) u_mx1 (
    .AClkH(clk), .AResetH(rst[1]), .AClkHEn(en[1]), .AAddr(addr[1]), .AMosi(mosi[1]),
    .AWrEn(wr[1]), .ARdEn(rd[1]), .AMiso(miso[1]), .ARdVld(vld[1]), .AWrCnt(cnt[1]), .ASig(sig[1]));
  ram_fake_mx #(.CAddrLen(A), .CDataLen(W), .CPortCnt(P), .CRdLat(2), .CSeed(8'h01)) u_mx2 (
    .AClkH(clk), .AResetH(rst[2]), .AClkHEn(en[2]), .AAddr(addr[2]), .AMosi(mosi[2]),
    .AWrEn(wr[2]), .ARdEn(rd[2]), .AMiso(miso[2]), .ARdVld(vld[2]), .AWrCnt(cnt[2]), .ASig(sig[2]));

  typedef struct {
    int         inst;
    int         port;
    logic [W-1:0] data;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   en_cnt [N];
  bit   fired  [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Expected read completes after 'lat' further enabled edges from now.
  task automatic push(input int inst, input int port, input logic [W-1:0] data, input int lat);
    exp_t e;
    e.inst = inst;
    e.port = port;
    e.data = data;
    e.due  = en_cnt[inst] + lat;
    exp_q.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      en_cnt[i] = 0;
      fired[i]  = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      fired[i] <= rst[i] | en[i];
      if (!rst[i] && en[i]) en_cnt[i] <= en_cnt[i] + 1;
    end
  end

  // Monitor: only looks at outputs just after an edge that could change them.
  always @(negedge clk) begin
    int idx;
    for (int i = 0; i < N; i++) begin
      if (fired[i]) begin
        for (int p = 0; p < P; p++) begin
          if (vld[i][p]) begin
            idx = -1;
            for (int k = 0; k < exp_q.size(); k++)
              if (idx < 0 && exp_q[k].inst == i && exp_q[k].port == p) idx = k;
            if (idx < 0) begin
              chk($sformatf("spurious_vld i%0d p%0d", i, p), 32'(vld[i][p]), 32'd0);
            end else begin
              chk($sformatf("rd_data i%0d p%0d", i, p), 32'(miso[i][p*W +: W]), 32'(exp_q[idx].data));
              chk($sformatf("rd_latency i%0d p%0d", i, p), 32'(en_cnt[i]), 32'(exp_q[idx].due));
              exp_q.delete(idx);
            end
          end else begin
            chk($sformatf("idle_miso i%0d p%0d", i, p), 32'(miso[i][p*W +: W]), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] rseq [3];
    rseq[0] = 8'h01;
    rseq[1] = 8'h02;
    rseq[2] = 8'h07;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; en[i] = 1'b1; addr[i] = '0; mosi[i] = '0; wr[i] = '0; rd[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;

    // Reset state
    chk("reset_vld", 32'(vld[0]), 32'd0);
    chk("reset_miso", 32'(miso[0]), 32'd0);
    chk("reset_wrcnt", cnt[0], 32'd0);
    chk("reset_sig", 32'(sig[0]), 32'd0);

    // Three back-to-back reads on port 0, latency 1
    for (int k = 0; k < 3; k++) begin
      rd[0] = 2'b01;
      push(0, 0, rseq[k], 1);
      @(negedge clk);
    end
    rd[0] = '0;
    @(negedge clk);
    @(negedge clk);

    // Dual write then single write
    wr[0] = 2'b11; mosi[0] = {8'h0F, 8'hA5};
    @(negedge clk);
    chk("wrcnt_dual", cnt[0], 32'd2);
    chk("sig_dual", 32'(sig[0]), 32'hAA);
    wr[0] = 2'b01; mosi[0] = {8'h00, 8'h01};
    @(negedge clk);
    chk("wrcnt_single", cnt[0], 32'd3);
    chk("sig_single", 32'(sig[0]), 32'h54);
    wr[0] = '0; mosi[0] = '0;
    @(negedge clk);
    chk("wrcnt_hold", cnt[0], 32'd3);
    chk("sig_hold", 32'(sig[0]), 32'h54);

    // Saturation
    force u_mx0.wr_cnt_reg = 32'hFFFFFFFE;
    #1;
    release u_mx0.wr_cnt_reg;
    wr[0] = 2'b11;
    @(negedge clk);
    chk("wrcnt_sat1", cnt[0], 32'hFFFFFFFF);
    @(negedge clk);
    chk("wrcnt_sat2", cnt[0], 32'hFFFFFFFF);
    wr[0] = '0;

    // Latency 3 with a two-cycle stall mid-flight
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    rd[1] = 2'b01;
    push(1, 0, 8'h01, 3);
    @(negedge clk);
    rd[1] = '0;
    en[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stall_no_early_vld", 32'(vld[1]), 32'd0);
    en[1] = 1'b1;
    repeat (3) @(negedge clk);

    // Reset one cycle after a read (latency 2): flushed, scrambler reseeded
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    rd[2] = 2'b01;
    @(negedge clk);
    rd[2] = '0;
    rst[2] = 1'b1;
    @(negedge clk);
    chk("flush_vld", 32'(vld[2]), 32'd0);
    rst[2] = 1'b0;
    rd[2] = 2'b01;
    push(2, 0, 8'h01, 2);
    @(negedge clk);
    rd[2] = '0;
    repeat (3) @(negedge clk);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
